// File: rtl/fir_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one fir_filter among NUM_CH AXI-Stream channels.
// Optional DRAIN watchdog and timeout_err port are enabled by defining FIR_ARB_WATCHDOG_EN.
module fir_stream_arbiter #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CH_W          = $clog2(NUM_CH),
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    input  logic [NUM_CH-1:0]            s_axis_tlast,
    output logic [NUM_CH-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]        fir_s_tdata,
    output logic                         fir_s_tvalid,
    output logic                         fir_s_tlast,
    input  logic                         fir_s_tready,
    input  logic [DATA_WIDTH-1:0]        fir_m_tdata,
    input  logic                         fir_m_tvalid,
    input  logic                         fir_m_tlast,
    output logic                         fir_m_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    output logic [CH_W-1:0]              m_axis_tdest,
    input  logic                         m_axis_tready,
`ifdef FIR_ARB_WATCHDOG_EN
    output logic                         timeout_err,
`endif
    output logic                         busy,
    output logic [CH_W-1:0]              active_ch
);

    if (NUM_CH < 2 || NUM_CH > 16 || DRAIN_TIMEOUT < 2) begin : g_param_err
        $error("fir_stream_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {StIdle, StSend, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CH_W-1:0] active_ch_q, active_ch_d;
    logic [CH_W-1:0] last_grant_q, last_grant_d;
    logic [CH_W-1:0] cand;
    logic [CH_W-1:0] req_idx;
    logic            req_found;
    logic            in_last_hs;
    logic            out_last_hs;

`ifdef FIR_ARB_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(DRAIN_TIMEOUT);
    localparam logic [WdW-1:0] WdMax = WdW'(DRAIN_TIMEOUT - 1);

    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_q, timeout_d;
`endif

    // First requester found scanning upward from the channel after the previous grant.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((32'(last_grant_q) + k) % NUM_CH);
            if (!req_found && s_axis_tvalid[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        fir_s_tvalid  = 1'b0;
        fir_s_tlast   = 1'b0;
        fir_s_tdata   = s_axis_tdata[active_ch_q*DATA_WIDTH +: DATA_WIDTH];
        if (state_q == StSend) begin
            fir_s_tvalid               = s_axis_tvalid[active_ch_q];
            fir_s_tlast                = s_axis_tlast[active_ch_q];
            s_axis_tready[active_ch_q] = fir_s_tready;
        end
    end

    assign in_last_hs  = fir_s_tvalid & fir_s_tready & fir_s_tlast;
    assign out_last_hs = fir_m_tvalid & m_axis_tready & fir_m_tlast;

    always_comb begin
        state_d      = state_q;
        active_ch_d  = active_ch_q;
        last_grant_d = last_grant_q;
`ifdef FIR_ARB_WATCHDOG_EN
        wd_cnt_d     = '0;
        timeout_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_found) begin
                    active_ch_d  = req_idx;
                    last_grant_d = req_idx;
                    state_d      = StSend;
                end
            end
            StSend: begin
                // A flushed tlast arriving with the input tlast closes the packet at once.
                if (in_last_hs) begin
                    state_d = out_last_hs ? StIdle : StDrain;
                end
            end
            StDrain: begin
                if (out_last_hs) begin
                    state_d = StIdle;
                end
`ifdef FIR_ARB_WATCHDOG_EN
                else if (wd_cnt_q == WdMax) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WdW'(1);
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            active_ch_q  <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            state_q      <= state_d;
            active_ch_q  <= active_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef FIR_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`endif

    assign m_axis_tdata  = fir_m_tdata;
    assign m_axis_tvalid = fir_m_tvalid;
    assign m_axis_tlast  = fir_m_tlast;
    assign fir_m_tready  = m_axis_tready;
    assign m_axis_tdest  = active_ch_q;
    assign active_ch     = active_ch_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Bench for fir_stream_arbiter: bench-side filter stub, transaction-level reference model,
// randomized and directed scenarios. Watchdog scenario compiled when FIR_ARB_WATCHDOG_EN is set.
`timescale 1ns/1ps
module tb_fir_stream_arbiter;
    localparam int unsigned DW  = 16;
    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 2;
    localparam int unsigned TO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*DW-1:0] s_axis_tdata;
    logic [NCH-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [DW-1:0]     fir_s_tdata;
    logic              fir_s_tvalid, fir_s_tlast, fir_s_tready;
    logic [DW-1:0]     fir_m_tdata;
    logic              fir_m_tvalid, fir_m_tlast, fir_m_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [CW-1:0]     m_axis_tdest, active_ch;
    logic              busy;
`ifdef FIR_ARB_WATCHDOG_EN
    logic              timeout_err;
`endif

    always #5 clk = ~clk;

    fir_stream_arbiter #(
        .DATA_WIDTH   (DW),
        .NUM_CH       (NCH),
        .CH_W         (CW),
        .DRAIN_TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .fir_s_tdata  (fir_s_tdata),
        .fir_s_tvalid (fir_s_tvalid),
        .fir_s_tlast  (fir_s_tlast),
        .fir_s_tready (fir_s_tready),
        .fir_m_tdata  (fir_m_tdata),
        .fir_m_tvalid (fir_m_tvalid),
        .fir_m_tlast  (fir_m_tlast),
        .fir_m_tready (fir_m_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tdest (m_axis_tdest),
        .m_axis_tready(m_axis_tready),
`ifdef FIR_ARB_WATCHDOG_EN
        .timeout_err  (timeout_err),
`endif
        .busy         (busy),
        .active_ch    (active_ch)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW:0] chq [NCH][$];  // per-channel pending beats, bit DW = tlast
    logic [DW:0] fq [$];        // filter stub output beats

    // Transaction-level model: owner channel (-1 when idle), input packet complete, drain age.
    int m_owner, m_last, m_active, m_drain;
    bit m_in_done, m_to;

    bit rnd, auto_f, own_m, prev_busy;
    int out_beats;
    int dut_grants [$];

    function automatic int rr_pick(input int last, input logic [NCH-1:0] req);
        for (int k = 1; k <= NCH; k++) begin
            if (req[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int c = 0; c < NCH; c++) if (chq[c].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_model();
        m_owner = -1; m_last = NCH - 1; m_active = 0; m_drain = 0;
        m_in_done = 1'b0; m_to = 1'b0; prev_busy = 1'b0;
        for (int c = 0; c < NCH; c++) chq[c].delete();
        fq.delete();
    endtask

    task automatic load_pkt(input int ch, input int len);
        for (int i = 0; i < len; i++) chq[ch].push_back({(i == len - 1), DW'($urandom)});
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            s_axis_tvalid[c] = chq[c].size() > 0;
            if (chq[c].size() > 0) begin
                s_axis_tdata[c*DW +: DW] = chq[c][0][DW-1:0];
                s_axis_tlast[c]          = chq[c][0][DW];
            end else begin
                s_axis_tdata[c*DW +: DW] = DW'($urandom);
                s_axis_tlast[c]          = 1'b0;
            end
        end
        fir_s_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (own_m) m_axis_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (auto_f) begin
            fir_m_tvalid = (fq.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            fir_m_tdata  = (fq.size() > 0) ? fq[0][DW-1:0] : '0;
            fir_m_tlast  = (fq.size() > 0) ? fq[0][DW] : 1'b0;
        end
    endtask

    // Checks the current cycle against the model, then advances the model across the edge.
    task automatic monitor(output bit s_hs, output bit m_hs);
        bit exp_fv, in_last_hs, out_last_hs;
        logic [NCH-1:0] exp_rdy;
        exp_rdy = '0;
        exp_fv  = 1'b0;
        if (m_owner >= 0 && !m_in_done) begin
            exp_rdy[m_owner] = fir_s_tready;
            exp_fv           = s_axis_tvalid[m_owner];
        end
        n_cmp++;
        if (s_axis_tready !== exp_rdy) begin
            n_err++; $display("FAIL mon_s_tready t=%0t: got %b exp %b", $time, s_axis_tready, exp_rdy);
        end
        n_cmp++;
        if (fir_s_tvalid !== exp_fv) begin
            n_err++; $display("FAIL mon_fir_s_tvalid t=%0t: got %b exp %b", $time, fir_s_tvalid, exp_fv);
        end
        n_cmp++;
        if (busy !== (m_owner >= 0)) begin
            n_err++; $display("FAIL mon_busy t=%0t: got %b exp %b", $time, busy, (m_owner >= 0));
        end
        n_cmp++;
        if (active_ch !== CW'(m_active) || m_axis_tdest !== CW'(m_active)) begin
            n_err++; $display("FAIL mon_active t=%0t: got ch %0d dest %0d exp %0d",
                              $time, active_ch, m_axis_tdest, m_active);
        end
        n_cmp++;
        if ({m_axis_tdata, m_axis_tvalid, m_axis_tlast, fir_m_tready} !==
            {fir_m_tdata, fir_m_tvalid, fir_m_tlast, m_axis_tready}) begin
            n_err++; $display("FAIL mon_out_path t=%0t: got %h/%b/%b rdy %b exp %h/%b/%b rdy %b",
                              $time, m_axis_tdata, m_axis_tvalid, m_axis_tlast, fir_m_tready,
                              fir_m_tdata, fir_m_tvalid, fir_m_tlast, m_axis_tready);
        end
        if (exp_fv) begin
            n_cmp++;
            if ({fir_s_tlast, fir_s_tdata} !== chq[m_owner][0]) begin
                n_err++; $display("FAIL mon_fir_s_beat t=%0t: got %h exp %h",
                                  $time, {fir_s_tlast, fir_s_tdata}, chq[m_owner][0]);
            end
        end
`ifdef FIR_ARB_WATCHDOG_EN
        n_cmp++;
        if (timeout_err !== m_to) begin
            n_err++; $display("FAIL mon_timeout_err t=%0t: got %b exp %b", $time, timeout_err, m_to);
        end
`endif
        s_hs        = exp_fv && fir_s_tready;
        in_last_hs  = s_hs && chq[m_owner][0][DW];
        m_hs        = fir_m_tvalid && m_axis_tready;
        out_last_hs = m_hs && fir_m_tlast;
        m_to        = 1'b0;
        if (m_owner < 0) begin
            if (s_axis_tvalid != '0) begin
                m_owner   = rr_pick(m_last, s_axis_tvalid);
                m_last    = m_owner;
                m_active  = m_owner;
                m_in_done = 1'b0;
            end
        end else if (!m_in_done) begin
            if (in_last_hs) begin
                if (out_last_hs) m_owner = -1;
                else begin m_in_done = 1'b1; m_drain = 0; end
            end
        end else begin
            if (out_last_hs) m_owner = -1;
`ifdef FIR_ARB_WATCHDOG_EN
            else if (m_drain == TO - 1) begin m_owner = -1; m_to = 1'b1; end
`endif
            m_drain++;
        end
    endtask

    task automatic tick();
        bit s_hs, m_hs;
        int s_ch;
        logic [DW:0] b;
        @(negedge clk);
        s_ch = m_owner;
        monitor(s_hs, m_hs);
        if (busy && !prev_busy) dut_grants.push_back(int'(active_ch));
        prev_busy = busy;
        @(posedge clk);
        #1;
        if (s_hs) begin
            b = chq[s_ch].pop_front();
            if (auto_f) begin
                // Stub filter: transformed echo plus a two-beat flush tail carrying tlast.
                fq.push_back({1'b0, b[DW-1:0] ^ 16'h5A5A});
                if (b[DW]) begin
                    fq.push_back({1'b0, 16'hF001});
                    fq.push_back({1'b1, 16'hF002});
                end
            end
        end
        if (m_hs) begin
            out_beats++;
            if (auto_f && fq.size() > 0) b = fq.pop_front();
        end
        drive();
        #1;
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((m_owner >= 0 || pending()) && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (m_owner >= 0 || pending()) begin
            n_err++; $display("FAIL %s_timeout: still busy after %0d cycles, exp idle", name, n);
        end
    endtask

    task automatic check_grants(input string name, input int g0, input int g1, input int n);
        n_cmp++;
        if (dut_grants.size() != n || dut_grants[0] != g0 || (n > 1 && dut_grants[1] != g1)) begin
            n_err++; $display("FAIL %s_grants: got %p exp %0d,%0d (count %0d)", name, dut_grants, g0, g1, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rnd = 1'b0; auto_f = 1'b1; own_m = 1'b1;
        fir_m_tvalid = 1'b0; fir_m_tlast = 1'b0; fir_m_tdata = '0;
        reset_model();
        drive();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || s_axis_tready !== '0 || fir_s_tvalid !== 1'b0 || active_ch !== '0) begin
            n_err++; $display("FAIL reset_state: got busy %b rdy %b fv %b ch %0d exp 0 0 0 0",
                              busy, s_axis_tready, fir_s_tvalid, active_ch);
        end
`ifdef FIR_ARB_WATCHDOG_EN
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_err++; $display("FAIL reset_timeout_err: got %b exp 0", timeout_err);
        end
`endif
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic test_single_packet();
        out_beats = 0;
        dut_grants.delete();
        chq[0].push_back({1'b0, 16'd10});
        chq[0].push_back({1'b0, 16'd20});
        chq[0].push_back({1'b0, 16'd30});
        chq[0].push_back({1'b1, 16'd40});
        drive();
        #1;
        n_cmp++;
        if (fir_s_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL t1_arb_cycle: got fv %b busy %b exp 0 0", fir_s_tvalid, busy);
        end
        tick();
        n_cmp++;
        if (fir_s_tvalid !== 1'b1 || fir_s_tdata !== 16'd10 || active_ch !== 2'd0) begin
            n_err++; $display("FAIL t1_first_beat: got fv %b data %0d ch %0d exp 1 10 0",
                              fir_s_tvalid, fir_s_tdata, active_ch);
        end
        run_until_idle(40, "t1");
        n_cmp++;
        if (busy !== 1'b0 || out_beats != 6) begin
            n_err++; $display("FAIL t1_done: got busy %b beats %0d exp 0 6", busy, out_beats);
        end
        check_grants("t1", 0, 0, 1);
    endtask

    task automatic test_two_requesters();
        dut_grants.delete();
        load_pkt(1, 3);
        load_pkt(3, 2);
        drive();
        run_until_idle(80, "t2");
        check_grants("t2", 1, 3, 2);
    endtask

    task automatic test_rr_wrap();
        dut_grants.delete();
        load_pkt(0, 2);
        load_pkt(2, 3);
        drive();
        run_until_idle(80, "t3");
        check_grants("t3", 0, 2, 2);
    endtask

    task automatic test_backpressure();
        bit pat [4];
        int k, n;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        k = 0; n = 0; out_beats = 0;
        own_m = 1'b0;
        m_axis_tready = 1'b1;
        load_pkt(3, 4);
        drive();
        while ((m_owner >= 0 || pending()) && n < 80) begin
            if (m_owner >= 0 && m_in_done) begin
                m_axis_tready = pat[k % 4];
                k++;
            end else begin
                m_axis_tready = 1'b1;
            end
            tick();
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0 || out_beats != 6 || fq.size() != 0) begin
            n_err++; $display("FAIL t4_backpressure: got busy %b beats %0d left %0d exp 0 6 0",
                              busy, out_beats, fq.size());
        end
        own_m = 1'b1;
    endtask

    task automatic test_back_to_back();
        dut_grants.delete();
        out_beats = 0;
        load_pkt(2, 1);
        load_pkt(2, 1);
        drive();
        run_until_idle(60, "b2b");
        check_grants("b2b", 2, 2, 2);
        n_cmp++;
        if (out_beats != 6) begin
            n_err++; $display("FAIL b2b_beats: got %0d exp 6", out_beats);
        end
    endtask

    task automatic test_last_collision();
        auto_f = 1'b0;
        fq.delete();
        fir_m_tvalid = 1'b0; fir_m_tlast = 1'b0; fir_m_tdata = 16'h1234;
        load_pkt(1, 3);
        drive();
        tick();
        fir_m_tvalid = 1'b1; fir_m_tlast = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || fir_s_tvalid !== 1'b1) begin
            n_err++; $display("FAIL early_out_tlast: got busy %b fv %b exp 1 1", busy, fir_s_tvalid);
        end
        fir_m_tvalid = 1'b0; fir_m_tlast = 1'b0;
        tick();
        fir_m_tvalid = 1'b1; fir_m_tlast = 1'b1;
        tick();
        fir_m_tvalid = 1'b0; fir_m_tlast = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL same_cycle_last: got busy %b exp 0", busy);
        end
        tick();
        auto_f = 1'b1;
        drive();
    endtask

    task automatic test_reset_mid_send();
        load_pkt(0, 6);
        drive();
        repeat (3) tick();
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (s_axis_tready !== '0 || fir_s_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got rdy %b fv %b busy %b exp 0 0 0",
                              s_axis_tready, fir_s_tvalid, busy);
        end
        reset_model();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        dut_grants.delete();
        load_pkt(0, 2);
        load_pkt(1, 2);
        drive();
        #1;
        run_until_idle(80, "t5");
        check_grants("t5", 0, 1, 2);
    endtask

    task automatic test_random();
        int mask;
        rnd = 1'b1;
        for (int it = 0; it < 30; it++) begin
            mask = int'($urandom_range(1, 15));
            for (int c = 0; c < NCH; c++) begin
                if (mask[c]) load_pkt(c, int'($urandom_range(1, 6)));
            end
            if ($urandom_range(0, 3) == 0) load_pkt(int'($urandom_range(0, NCH - 1)), 1);
            drive();
            run_until_idle(400, "rand");
        end
        rnd = 1'b0;
        fq.delete();
        drive();
        repeat (4) tick();
    endtask

`ifdef FIR_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int first, width;
        first = -1; width = 0;
        auto_f = 1'b0;
        fq.delete();
        fir_m_tvalid = 1'b0; fir_m_tlast = 1'b0;
        load_pkt(3, 1);
        drive();
        tick();
        tick();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (timeout_err === 1'b1) begin
                if (first < 0) first = k;
                width++;
            end
        end
        n_cmp++;
        if (first != 16 || width != 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL watchdog: got at %0d width %0d busy %b exp 16 1 0",
                              first, width, busy);
        end
        auto_f = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_two_requesters();
        test_rr_wrap();
        test_backpressure();
        test_back_to_back();
        test_last_collision();
        test_reset_mid_send();
        test_random();
`ifdef FIR_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
